hc595_chain_rx: RTL and testbench

HC595_CHAIN_RX -- requirements
Module: hc595_chain_rx

---
 rtl/hc595_pkg.sv | 13 +
 rtl/hc595_sync_edge.sv | 36 +++
 rtl/hc595_chain_rx.sv | 143 ++++++++++++++
 tb/tb_hc595_chain_rx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/hc595_pkg.sv
// Shared types and default sizing for the 74HC595-chain receiver.
package hc595_pkg;

    localparam int DEFAULT_NUM_BYTES   = 6;
    localparam int DEFAULT_SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2
    } state_e;

endpackage

// File: rtl/hc595_sync_edge.sv
// Multi-flop synchronizer plus rising-edge detector for one asynchronous pin.
module hc595_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] fill_q;
    logic                   prev_q;
    logic                   armed_q;

    // fill_q marks when the chain output holds a real post-reset sample; the
    // detector arms one cycle later so a pin already high never looks like an edge.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            fill_q  <= '0;
            prev_q  <= 1'b0;
            armed_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
            fill_q  <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            prev_q  <= sync_q[SYNC_STAGES-1];
            armed_q <= fill_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = armed_q & sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/hc595_chain_rx.sv
// Receiver emulating a cascade of 74HC595 shift/storage registers on a single clock.
// Optional macro HC595_RX_FRAME_CHECK_EN rejects latches that do not follow exactly W bits.
module hc595_chain_rx
    import hc595_pkg::*;
#(
    parameter int NUM_BYTES   = DEFAULT_NUM_BYTES,
    parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
    input  logic                               s_clk,
    input  logic                               s_reset,
    input  logic                               data_in,
    input  logic                               data_clock,
    input  logic                               latch_in,
    output logic [8*NUM_BYTES-1:0]             data_out,
    output logic                               data_valid,
    output logic                               frame_err,
    output logic [$clog2(8*NUM_BYTES+1)-1:0]   bit_count
);

    localparam int W  = 8 * NUM_BYTES;
    localparam int CW = $clog2(W + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(W);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic din_s, din_rise_unused;
    logic dclk_sync_unused, dclk_rise;
    logic latch_sync_unused, latch_rise;

    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_din (
        .clk_i(s_clk), .rst_ni(s_reset), .d_i(data_in),
        .sync_o(din_s), .rise_o(din_rise_unused)
    );
    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_dclk (
        .clk_i(s_clk), .rst_ni(s_reset), .d_i(data_clock),
        .sync_o(dclk_sync_unused), .rise_o(dclk_rise)
    );
    hc595_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_latch (
        .clk_i(s_clk), .rst_ni(s_reset), .d_i(latch_in),
        .sync_o(latch_sync_unused), .rise_o(latch_rise)
    );

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [W-1:0]    shreg_q, shreg_d;
    logic [W-1:0]    dout_q, dout_d;
    logic            valid_q, valid_d;
`ifdef HC595_RX_FRAME_CHECK_EN
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
`endif

    always_ff @(posedge s_clk) begin
        if (!s_reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
`ifdef HC595_RX_FRAME_CHECK_EN
            err_q   <= 1'b0;
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
`ifdef HC595_RX_FRAME_CHECK_EN
            err_q   <= err_d;
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        dout_d  = dout_q;
        valid_d = 1'b0;
`ifdef HC595_RX_FRAME_CHECK_EN
        err_d   = 1'b0;
        ovf_d   = ovf_q;
`endif

        // Latch sees the pre-shift register, so a coincident shift lands in the next frame.
        if (latch_rise) begin
`ifdef HC595_RX_FRAME_CHECK_EN
            if (cnt_q == CNT_FULL && !ovf_q) begin
                dout_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                err_d   = 1'b1;
            end
            ovf_d   = 1'b0;
`else
            dout_d  = shreg_q;
            valid_d = 1'b1;
`endif
            state_d = IDLE;
            cnt_d   = '0;
        end

        if (dclk_rise) begin
            shreg_d = {shreg_q[W-2:0], din_s};
            if (latch_rise) begin
                state_d = SHIFT;
                cnt_d   = CNT_ONE;
            end else begin
                case (state_q)
                    IDLE: begin
                        state_d = SHIFT;
                        cnt_d   = CNT_ONE;
                    end
                    SHIFT: begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_d == CNT_FULL) state_d = FULL;
                    end
                    FULL: begin
`ifdef HC595_RX_FRAME_CHECK_EN
                        ovf_d = 1'b1;
`endif
                    end
                    default: begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                endcase
            end
        end
    end

    assign data_out   = dout_q;
    assign data_valid = valid_q;
    assign bit_count  = cnt_q;
`ifdef HC595_RX_FRAME_CHECK_EN
    assign frame_err  = err_q;
`else
    assign frame_err  = 1'b0;
`endif

endmodule

// File: tb/tb_hc595_chain_rx.sv
// Directed + randomized bench for hc595_chain_rx against a bit-history reference model.
module tb_hc595_chain_rx;

    localparam int W     = 48;
    localparam int CW    = $clog2(W + 1);
    localparam int SYNC  = 2;
    localparam int HALF  = 4;

    logic          s_clk, s_reset, data_in, data_clock, latch_in;
    logic [W-1:0]  data_out;
    logic          data_valid, frame_err;
    logic [CW-1:0] bit_count;

    hc595_chain_rx #(.NUM_BYTES(6), .SYNC_STAGES(SYNC)) dut (
        .s_clk(s_clk), .s_reset(s_reset), .data_in(data_in),
        .data_clock(data_clock), .latch_in(latch_in), .data_out(data_out),
        .data_valid(data_valid), .frame_err(frame_err), .bit_count(bit_count)
    );

    initial s_clk = 1'b0;
    always #5 s_clk = ~s_clk;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int valid_cnt = 0;
    int err_cnt = 0;
    int valid_cyc = 0;

    always @(posedge s_clk) cyc++;
    always @(negedge s_clk) begin
        if (data_valid) begin
            valid_cnt++;
            valid_cyc = cyc;
        end
        if (frame_err) err_cnt++;
    end

    // Reference model: every bit shifted since reset, bits since the last latch, storage.
    bit           hist[$];
    int           nbits = 0;
    logic [W-1:0] model_dout = '0;

    function automatic logic [W-1:0] model_shreg();
        logic [W-1:0] v = '0;
        for (int i = 0; i < W; i++)
            if (i < hist.size()) v[i] = hist[hist.size() - 1 - i];
        return v;
    endfunction

    function automatic int sat_count();
        return (nbits > W) ? W : nbits;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic align();
        int ph;
        @(negedge s_clk);
        ph = $urandom_range(1, 8);
        if (ph >= 5) ph++;
        #(ph);
    endtask

    task automatic push_bit(input bit b);
        hist.push_back(b);
        if (hist.size() > W) void'(hist.pop_front());
        nbits++;
    endtask

    task automatic send_bit(input bit b);
        data_in    = b;
        data_clock = 1'b0;
        #(HALF * 10);
        data_clock = 1'b1;
        #(HALF * 10);
        push_bit(b);
    endtask

    task automatic send_val(input logic [63:0] val, input int n);
        logic [63:0] v;
        v = val;
        for (int i = n - 1; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_rand(input int n);
        for (int i = 0; i < n; i++) send_bit(1'($urandom));
    endtask

    // with_clk raises data_clock together with latch_in, shifting bit b into the next frame.
    task automatic do_latch(input string tag, input bit with_clk, input bit b);
        int v0, e0, pc;
        bit good;
        logic [W-1:0] exp_dout;
        v0 = valid_cnt;
        e0 = err_cnt;
`ifdef HC595_RX_FRAME_CHECK_EN
        good = (nbits == W);
`else
        good = 1'b1;
`endif
        exp_dout = good ? model_shreg() : model_dout;
        if (with_clk) begin
            data_in    = b;
            data_clock = 1'b0;
            #(HALF * 10);
            data_clock = 1'b1;
        end
        latch_in = 1'b1;
        pc = cyc;
        #(10 * (SYNC + 4));
        latch_in = 1'b0;
        #(10 * 4);
        model_dout = exp_dout;
        nbits = 0;
        if (with_clk) push_bit(b);
        check({tag, "_dout"}, 64'(data_out), 64'(exp_dout));
        check({tag, "_valid"}, 64'(valid_cnt - v0), good ? 64'd1 : 64'd0);
        check({tag, "_err"}, 64'(err_cnt - e0), good ? 64'd0 : 64'd1);
        check({tag, "_cnt"}, 64'(bit_count), 64'(nbits));
        if (good) check({tag, "_lat"}, 64'(valid_cyc - pc), 64'(SYNC + 1));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_dout"}, 64'(data_out), 64'd0);
        check({tag, "_valid"}, 64'(data_valid), 64'd0);
        check({tag, "_err"}, 64'(frame_err), 64'd0);
        check({tag, "_cnt"}, 64'(bit_count), 64'd0);
    endtask

    initial begin
        #(3_000_000);
        $display("FAIL watchdog: time limit reached, observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int v0, e0, len;
        s_reset = 1'b0; data_in = 1'b0; data_clock = 1'b0; latch_in = 1'b0;
        repeat (4) @(negedge s_clk);
        check_zero("reset");
        align();
        s_reset = 1'b1;
        #(10 * 8);

        send_val(64'hFC60DAF266B6, 48);
        check("full_cnt48", 64'(bit_count), 64'(sat_count()));
        do_latch("full", 1'b0, 1'b0);

        send_rand(40);
        check("short_cnt40", 64'(bit_count), 64'(sat_count()));
        do_latch("short", 1'b0, 1'b0);

        send_rand(50);
        check("over_cnt48", 64'(bit_count), 64'(sat_count()));
        do_latch("over", 1'b0, 1'b0);

        send_rand(48);
        do_latch("after_over", 1'b0, 1'b0);

        send_val(64'hFC60DAF266B6, 48);
        do_latch("coinc", 1'b1, 1'b1);
        check("coinc_ref", 64'(model_dout), 64'hFC60DAF266B6);
        send_rand(47);
        check("coinc_cnt48", 64'(bit_count), 64'(sat_count()));
        do_latch("coinc_next", 1'b0, 1'b0);

        send_rand(20);
        v0 = valid_cnt;
        e0 = err_cnt;
        s_reset = 1'b0;
        @(posedge s_clk);
        @(negedge s_clk);
        check_zero("midreset");
        hist.delete();
        nbits = 0;
        model_dout = '0;
        data_clock = 1'b1;
        latch_in = 1'b1;
        align();
        s_reset = 1'b1;
        #(10 * 10);
        check("highpin_valid", 64'(valid_cnt - v0), 64'd0);
        check("highpin_err", 64'(err_cnt - e0), 64'd0);
        check("highpin_cnt", 64'(bit_count), 64'd0);
        latch_in = 1'b0;
        #(10 * 6);
        send_val(64'hAAAAAAAAAAAA, 48);
        do_latch("post_reset", 1'b0, 1'b0);

        for (int f = 0; f < 100; f++) begin
            align();
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(40, 56)) : W;
            send_rand(len);
            check("rand_cnt", 64'(bit_count), 64'(sat_count()));
            do_latch("rand", 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
